// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, op numbering,
// op-class ranges and PC-select values.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } state_e;

    localparam logic [5:0] OP_ADDI  = 6'd0;
    localparam logic [5:0] OP_ADD   = 6'd10;
    localparam logic [5:0] OP_LB    = 6'd19;
    localparam logic [5:0] OP_LW    = 6'd21;
    localparam logic [5:0] OP_SB    = 6'd24;
    localparam logic [5:0] OP_SW    = 6'd26;
    localparam logic [5:0] OP_BEQ   = 6'd27;
    localparam logic [5:0] OP_JAL   = 6'd33;
    localparam logic [5:0] OP_JALR  = 6'd34;
    localparam logic [5:0] OP_LUI   = 6'd35;
    localparam logic [5:0] OP_AUIPC = 6'd36;

    localparam logic [5:0] OP_LD_FIRST = 6'd19;
    localparam logic [5:0] OP_LD_LAST  = 6'd23;
    localparam logic [5:0] OP_ST_FIRST = 6'd24;
    localparam logic [5:0] OP_ST_LAST  = 6'd26;
    localparam logic [5:0] OP_BR_FIRST = 6'd27;
    localparam logic [5:0] OP_BR_LAST  = 6'd32;
    localparam logic [5:0] OP_MAX      = OP_AUIPC;

    localparam logic [1:0] PC_SEL_SEQ  = 2'd0;
    localparam logic [1:0] PC_SEL_BR   = 2'd1;
    localparam logic [1:0] PC_SEL_JALR = 2'd2;

    function automatic logic is_load(input logic [5:0] op);
        return (op >= OP_LD_FIRST) && (op <= OP_LD_LAST);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op >= OP_ST_FIRST) && (op <= OP_ST_LAST);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op >= OP_BR_FIRST) && (op <= OP_BR_LAST);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating 8-bit wait counter for one memory access; flags when the count
// reaches MEM_TIMEOUT (0 disables). MEM_TIMEOUT must not exceed 255.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 8'd0;
        end else if (count_en && (cnt_q != 8'hff)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with sticky fault.
// Optional MULTICYCLE_CTRL_PERF_EN adds perf_cycles / perf_retired counters.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic        br_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_is_data,
    output logic        mem_write,
    output logic        ir_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        retire,
    output logic        fault,
    output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retired
`endif
);

    state_e state_q;
    state_e state_d;
    logic   expired;

    // Any state change clears the timer, which covers the MEM->FETCH hop of a store.
    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_d != state_q),
        .count_en(mem_req && !mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack)      state_d = ST_DECODE;
                else if (expired) state_d = ST_FAULT;
            end
            ST_DECODE: state_d = (op > OP_MAX) ? ST_FAULT : ST_EXEC;
            ST_EXEC: begin
                if (is_load(op) || is_store(op)) state_d = ST_MEM;
                else if (is_branch(op))          state_d = ST_FETCH;
                else                             state_d = ST_WB;
            end
            ST_MEM: begin
                if (mem_ack)      state_d = is_load(op) ? ST_WB : ST_FETCH;
                else if (expired) state_d = ST_FAULT;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_FAULT:  state_d = ST_FAULT;
            default:   state_d = ST_FAULT;
        endcase
    end

    always_comb begin
        mem_req     = 1'b0;
        mem_is_data = 1'b0;
        mem_write   = 1'b0;
        ir_we       = 1'b0;
        rf_we       = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = PC_SEL_SEQ;
        retire      = 1'b0;
        fault       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
            end
            ST_EXEC: begin
                if (is_branch(op)) begin
                    pc_we  = 1'b1;
                    pc_sel = br_taken ? PC_SEL_BR : PC_SEL_SEQ;
                    retire = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req     = 1'b1;
                mem_is_data = 1'b1;
                mem_write   = is_store(op);
                if (is_store(op)) begin
                    pc_we  = mem_ack;
                    retire = mem_ack;
                end
            end
            ST_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                if (op == OP_JAL)       pc_sel = PC_SEL_BR;
                else if (op == OP_JALR) pc_sel = PC_SEL_JALR;
            end
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d;
    logic [31:0] perf_retired_q, perf_retired_d;

    always_comb begin
        perf_cycles_d  = perf_cycles_q;
        perf_retired_d = perf_retired_q;
        if ((state_q != ST_BOOT) && (state_q != ST_FAULT)) perf_cycles_d = perf_cycles_q + 32'd1;
        if (retire) perf_retired_d = perf_retired_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_cycles_q  <= 32'd0;
            perf_retired_q <= 32'd0;
        end else begin
            perf_cycles_q  <= perf_cycles_d;
            perf_retired_q <= perf_retired_d;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_retired = perf_retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into an
// expected per-cycle output trace from the sequencing rules, then replayed.
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam logic [2:0] S_BOOT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_FAULT = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        br_taken;
    logic        mem_ack;
    logic        mem_req, mem_is_data, mem_write, ir_we, rf_we, pc_we, retire, fault;
    logic [1:0]  pc_sel;
    logic [2:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_retired;
`endif

    int checks = 0;
    int failures = 0;
    string cur_test = "none";
    logic [12:0] exp_q[$];
    logic        ack_q[$];
    bit          noise_en = 0;
    int unsigned exp_cyc = 0;
    int unsigned exp_ret = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .op(op), .br_taken(br_taken), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_is_data(mem_is_data), .mem_write(mem_write),
        .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .retire(retire), .fault(fault), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_retired(perf_retired)
`endif
    );

    function automatic logic [12:0] mk(input logic [2:0] st, input logic req, input logic dat,
                                       input logic wr, input logic ir, input logic rf,
                                       input logic pcw, input logic [1:0] sel,
                                       input logic ret, input logic flt);
        return {st, req, dat, wr, ir, rf, pcw, sel, ret, flt};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {state, mem_req, mem_is_data, mem_write, ir_we, rf_we, pc_we, pc_sel, retire, fault};
    endfunction

    function automatic void push(input logic a, input logic [12:0] v);
        ack_q.push_back(a);
        exp_q.push_back(v);
    endfunction

    function automatic logic noise();
        return noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    function automatic void push_fault();
        for (int i = 0; i < 3; i++) push(noise(), mk(S_FAULT, 0, 0, 0, 0, 0, 0, 2'd0, 0, 1));
    endfunction

    // Expected trace of one instruction: fd / md are ack delays in FETCH / MEM.
    function automatic void build_instr(input int o, input logic bt, input int fd, input int md);
        bit ld, st, br;
        logic [1:0] sel;
        ld = (o >= 19 && o <= 23);
        st = (o >= 24 && o <= 26);
        br = (o >= 27 && o <= 32);
        if (fd > TO) begin
            for (int i = 0; i <= TO; i++) push(0, mk(S_FETCH, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0));
            push_fault();
            return;
        end
        for (int i = 0; i < fd; i++) push(0, mk(S_FETCH, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        push(1, mk(S_FETCH, 1, 0, 0, 1, 0, 0, 2'd0, 0, 0));
        push(noise(), mk(S_DECODE, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        if (o > 36) begin
            push_fault();
            return;
        end
        if (br) begin
            push(noise(), mk(S_EXEC, 0, 0, 0, 0, 0, 1, {1'b0, bt}, 1, 0));
            return;
        end
        push(noise(), mk(S_EXEC, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        if (ld || st) begin
            if (md > TO) begin
                for (int i = 0; i <= TO; i++) push(0, mk(S_MEM, 1, 1, st, 0, 0, 0, 2'd0, 0, 0));
                push_fault();
                return;
            end
            for (int i = 0; i < md; i++) push(0, mk(S_MEM, 1, 1, st, 0, 0, 0, 2'd0, 0, 0));
            push(1, mk(S_MEM, 1, 1, st, 0, 0, st, 2'd0, st, 0));
            if (st) return;
        end
        sel = (o == 33) ? 2'd1 : (o == 34) ? 2'd2 : 2'd0;
        push(noise(), mk(S_WB, 0, 0, 0, 0, 1, 1, sel, 1, 0));
    endfunction

    task automatic step(input logic a, input logic [12:0] e);
        mem_ack = a;
        @(negedge clk);
        checks++;
        if (obs_vec() !== e) begin
            failures++;
            $display("FAIL %s: outputs got %h expected %h at %0t", cur_test, obs_vec(), e, $time);
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== exp_cyc || perf_retired !== exp_ret) begin
            failures++;
            $display("FAIL %s_perf: got cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                     cur_test, perf_cycles, perf_retired, exp_cyc, exp_ret);
        end
`endif
        if (e[12:10] != S_BOOT && e[12:10] != S_FAULT) exp_cyc++;
        if (e[1]) exp_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_queue();
        while (exp_q.size() > 0) step(ack_q.pop_front(), exp_q.pop_front());
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (obs_vec() !== 13'd0) begin
            failures++;
            $display("FAIL %s: outputs got %h expected 0000", name, obs_vec());
        end
`ifdef MULTICYCLE_CTRL_PERF_EN
        checks++;
        if (perf_cycles !== 32'd0 || perf_retired !== 32'd0) begin
            failures++;
            $display("FAIL %s_perf: got cyc=%0d ret=%0d expected 0/0", name, perf_cycles, perf_retired);
        end
`endif
    endtask

    // Holds reset across a clock edge, checks the idle outputs, releases and
    // queues the single BOOT cycle that must follow.
    task automatic do_reset();
        reset = 1'b0;
        mem_ack = 1'b0;
        #1;
        @(posedge clk);
        #1;
        check_zero({cur_test, "_in_reset"});
        exp_cyc = 0;
        exp_ret = 0;
        reset = 1'b1;
        push(0, mk(S_BOOT, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
    endtask

    task automatic run_instr(input int o, input logic bt, input int fd, input int md);
        op = 6'(o);
        br_taken = bt;
        build_instr(o, bt, fd, md);
        run_queue();
    endtask

    task automatic test_reset();
        cur_test = "reset";
        do_reset();
        run_queue();
    endtask

    task automatic test_add();
        cur_test = "add";
        run_instr(10, 0, 0, 0);
    endtask

    task automatic test_load();
        cur_test = "lw_delay3";
        run_instr(21, 0, 0, 3);
    endtask

    task automatic test_branch();
        cur_test = "beq_taken";
        run_instr(27, 1, 0, 0);
        cur_test = "bne_not_taken";
        run_instr(28, 0, 1, 0);
    endtask

    task automatic test_jalr_store();
        cur_test = "jalr";
        run_instr(34, 0, 0, 0);
        cur_test = "jal";
        run_instr(33, 1, 2, 0);
        cur_test = "sb";
        run_instr(24, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        int o;
        cur_test = "random";
        noise_en = 1;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 5))
                0: o = $urandom_range(0, 18);
                1: o = $urandom_range(19, 23);
                2: o = $urandom_range(24, 26);
                3: o = $urandom_range(27, 32);
                default: o = $urandom_range(33, 36);
            endcase
            run_instr(o, 1'($urandom_range(0, 1)), $urandom_range(0, TO), $urandom_range(0, TO));
        end
        noise_en = 0;
    endtask

    task automatic test_timeout();
        cur_test = "fetch_timeout";
        run_instr(10, 0, TO + 1, 0);
        cur_test = "fetch_timeout_reset";
        do_reset();
        run_queue();
        cur_test = "mem_timeout";
        run_instr(22, 0, 0, TO + 3);
        cur_test = "mem_timeout_reset";
        do_reset();
        run_queue();
    endtask

    task automatic test_illegal_op();
        cur_test = "illegal_op40";
        run_instr(40, 0, 1, 0);
        cur_test = "illegal_reset";
        do_reset();
        run_queue();
        cur_test = "illegal_op_rand";
        run_instr($urandom_range(37, 63), 0, 0, 0);
        do_reset();
        run_queue();
    endtask

    task automatic test_reset_mid_store();
        logic [12:0] e;
        logic a;
        cur_test = "reset_mid_store";
        op = 6'd25;
        br_taken = 1'b0;
        build_instr(25, 0, 0, 3);
        while (exp_q.size() > 0) begin
            a = ack_q.pop_front();
            e = exp_q.pop_front();
            if (e[12:10] == S_MEM) begin
                mem_ack = 1'b0;
                #2;
                reset = 1'b0;
                #1;
                check_zero("reset_mid_store_async");
                break;
            end
            step(a, e);
        end
        exp_q.delete();
        ack_q.delete();
        @(posedge clk);
        #1;
        exp_cyc = 0;
        exp_ret = 0;
        reset = 1'b1;
        push(0, mk(S_BOOT, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0));
        cur_test = "after_mid_reset";
        run_instr(10, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        mem_ack = 1'b0;
        op = 6'd0;
        br_taken = 1'b0;
        test_reset();
        test_add();
        test_load();
        test_branch();
        test_jalr_store();
        test_back_to_back();
        test_timeout();
        test_illegal_op();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the single-cycle ALU/load-store datapath. It steps each instruction through fetch, decode, execute, memory and writeback over a shared single-port memory, and issues the datapath enables: instruction-register latch, register-file write, and PC update/select. It sits between the decoder's 6-bit op output and the memory/register-file/PC registers, and reports a sticky fault on illegal ops or memory timeout.

## Interface
- `MEM_TIMEOUT`, default 255: max wait cycles for `mem_ack` per access; 0 disables the timeout.
- `clk`  in  1  core clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `op`  in  6  decoded op from latched IR (0–18 ALU, 19–23 loads, 24–26 stores, 27–32 branches, 33 JAL, 34 JALR, 35 LUI, 36 AUIPC)
- `br_taken`  in  1  branch comparator result, valid in EXEC
- `mem_ack`  in  1  memory completion; may be high in the same cycle as `mem_req`
- `mem_req`  out  1  memory access request
- `mem_is_data`  out  1  0 = address from PC (fetch), 1 = address from daddr
- `mem_write`  out  1  store access (the datapath supplies dwe/dwdata)
- `ir_we`  out  1  latch instruction word
- `rf_we`  out  1  register-file write enable
- `pc_we`  out  1  PC update enable
- `pc_sel`  out  2  0 = PC+4, 1 = branch/JAL target, 2 = JALR target
- `retire`  out  1  one-cycle pulse per completed instruction
- `fault`  out  1  sticky error flag
- `state`  out  3  current state, for debug

## Operation
- States: BOOT, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- BOOT: the reset state. All outputs are 0. Moves to FETCH on the first clock after `reset` deasserts.
- FETCH: `mem_req`=1, `mem_is_data`=0. On `mem_ack`: `ir_we`=1 in the same cycle, then DECODE.
- DECODE: one cycle for register read. If `op`>36, go to FAULT; otherwise go to EXEC.
- EXEC, by op class:
  - ALU ops, LUI, AUIPC, JAL, JALR: go to WB.
  - Loads and stores: go to MEM.
  - Branches: `pc_we`=1, `pc_sel`=`br_taken`?1:0, `retire`=1, then FETCH.
- MEM: `mem_req`=1, `mem_is_data`=1, `mem_write`=1 for ops 24–26. On `mem_ack`:
  - Loads go to WB.
  - Stores assert `pc_we`=1, `pc_sel`=0, `retire`=1, then go to FETCH.
- WB: `rf_we`=1 and `pc_we`=1. `pc_sel` is 1 for JAL, 2 for JALR, 0 otherwise. `retire`=1. Then FETCH.
- Timeout: the wait counter clears on entry to FETCH or MEM and increments each cycle that `mem_req`=1 and `mem_ack`=0. When the counter equals `MEM_TIMEOUT` (nonzero), go to FAULT. If `mem_ack` and the timeout occur in the same cycle, `mem_ack` wins.
- FAULT: `fault`=1; all other outputs are 0. Only `reset` leaves FAULT.
- Outputs are decoded from the state (Moore). The exceptions are `ir_we`, the MEM-state `pc_we`, and `retire`, which are qualified by `mem_ack`.

## Timing
- Reset (asynchronous assert): state=BOOT and every output is 0 immediately, including mid-access. An in-flight memory request is simply dropped.
- Minimum latency with zero-wait memory (ack in the request cycle):
  - ALU/U-type/jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each cycle of `mem_ack` delay adds one cycle.
- `mem_req` stays high continuously until the cycle `mem_ack` is seen, and drops in the following cycle.
- `retire` is exactly one cycle wide per instruction.
- The wait counter is 8 bits wide and saturates. `MEM_TIMEOUT` must be ≤ 255.

## Configuration
- `MULTICYCLE_CTRL_PERF_EN` defined: adds two 32-bit outputs, `perf_cycles` and `perf_retired`.
  - `perf_cycles` counts every cycle outside BOOT and FAULT.
  - `perf_retired` counts `retire` pulses.
  - Both reset to 0 and wrap modulo 2^32.
- `MULTICYCLE_CTRL_PERF_EN` undefined: the ports and counters are absent and the logic is otherwise identical.

## Structure
- Shared package `ctrl_pkg`:
  - state encoding: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=6;
  - op constants OP_ADDI=0 … OP_AUIPC=36, plus class ranges OP_LD_FIRST/LAST, OP_ST_FIRST/LAST, OP_BR_FIRST/LAST;
  - `pc_sel` encodings PC_SEL_SEQ/BR/JALR.
- One sub-module, `mem_wait_timer`, holds the wait counter and compare. Inputs: clear, count enable. Output: `expired`.

## Test plan
- ADD (op 10), zero-wait memory → `ir_we` in cycle 1, `rf_we`+`pc_we` with `pc_sel`=0 in cycle 4, `retire` in cycle 4, FETCH in cycle 5.
- LW (op 21), `mem_ack` delayed 3 cycles in MEM → `mem_req`/`mem_is_data` high for 4 cycles, WB `rf_we` in cycle 8, `retire` once.
- BEQ (op 27), `br_taken`=1 → EXEC asserts `pc_we`, `pc_sel`=1, `retire`; no `rf_we`; 3 cycles total.
- JALR (op 34) → WB asserts `rf_we`=1 and `pc_sel`=2. SB (op 24) → `mem_write`=1 in MEM, no `rf_we`.
- `MEM_TIMEOUT`=4, `mem_ack` never asserted in FETCH → FAULT after 4 wait cycles, `fault`=1 held. Separately, op=40 in DECODE → FAULT. In both cases `reset` low returns to BOOT with all outputs 0.
- `reset` asserted mid-MEM of a store → outputs 0 immediately, no `retire`. After release: BOOT for 1 cycle, then FETCH. With the perf macro enabled, both counters are 0.
